// File: rtl/prog_load_ctrl.sv
// -----------------------------------------------------------------------------
// prog_load_ctrl
//
// Boot-time program loader. After reset the controller listens for UART bytes.
// Bytes are packed big-endian into 32-bit words and written to program memory
// from address 0 upward. When the byte stream goes quiet for TIMEOUT_CYCLES,
// or the memory is full, the controller hands the memory port to the CPU fetch
// stage and releases the pipeline. If no byte ever arrives, the preloaded
// memory image runs unchanged.
//
// Ports
//   clk, reset_n       clock, synchronous active-low reset
//   rx_valid, rx_data  one-cycle byte strobe and byte from the UART receiver
//   cpu_addr           fetch byte address, passed through to memory in RUN
//   pmem_addr          program memory byte address
//   pmem_we            program memory write enable (one cycle per word)
//   pmem_wdata         program memory write data
//   cpu_run            1 = pipeline may advance
//   load_words         number of words written during this load
//   load_error         sticky: a partial word was discarded at timeout
//   state              IDLE=00, LOAD=01, RUN=10
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | no byte seen yet; timeout here runs the preloaded image
// LOAD  | receiving bytes; each completed word is written one cycle later
// RUN   | memory belongs to the fetch stage; terminal until reset
// -----------------------------------------------------------------------------
module prog_load_ctrl #(
    parameter int unsigned MEM_WORDS      = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 400000000
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         rx_valid,
    input  logic [7:0]                   rx_data,
    input  logic [31:0]                  cpu_addr,
    output logic [31:0]                  pmem_addr,
    output logic                         pmem_we,
    output logic [31:0]                  pmem_wdata,
    output logic                         cpu_run,
    output logic [$clog2(MEM_WORDS):0]   load_words,
    output logic                         load_error,
    output logic [1:0]                   state
);

    localparam int CW = $clog2(MEM_WORDS) + 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] W_LAST = CW'(MEM_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LOAD = 2'b01,
        S_RUN  = 2'b10
    } state_t;

    state_t          state_q;
    logic [TW-1:0]   timer;
    logic [31:0]     word_buf;
    logic [1:0]      byte_idx;
    logic [CW-1:0]   word_cnt;
    logic [31:0]     wr_addr;
    // Set when the word just completed must be followed directly by RUN:
    // either the memory is now full, or a timeout coincided with the 4th byte.
    logic            run_pending;

    assign state      = state_q;
    assign load_words = word_cnt;
    // Fetch addresses bypass the register so the CPU sees memory with no
    // extra latency once it owns the port.
    assign pmem_addr  = (state_q == S_RUN) ? cpu_addr : wr_addr;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            timer       <= '0;
            word_buf    <= '0;
            byte_idx    <= '0;
            word_cnt    <= '0;
            wr_addr     <= '0;
            run_pending <= 1'b0;
            pmem_we     <= 1'b0;
            pmem_wdata  <= '0;
            cpu_run     <= 1'b0;
            load_error  <= 1'b0;
        end else begin
            // Write strobe and its address last exactly one cycle.
            pmem_we <= 1'b0;
            wr_addr <= '0;

            case (state_q)
                S_IDLE: begin
                    if (rx_valid) begin
                        state_q  <= S_LOAD;
                        timer    <= '0;
                        word_buf <= {word_buf[23:0], rx_data};
                        byte_idx <= byte_idx + 2'd1;
                    end else if (timer == T_LAST) begin
                        state_q <= S_RUN;
                        cpu_run <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                S_LOAD: begin
                    if (run_pending) begin
                        // The deferred write is on the bus this cycle; any
                        // byte arriving now is dropped.
                        state_q     <= S_RUN;
                        cpu_run     <= 1'b1;
                        run_pending <= 1'b0;
                    end else if (rx_valid && (word_cnt < CW'(MEM_WORDS))) begin
                        timer    <= '0;
                        word_buf <= {word_buf[23:0], rx_data};
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            pmem_we    <= 1'b1;
                            pmem_wdata <= {word_buf[23:0], rx_data};
                            wr_addr    <= 32'({word_cnt, 2'b00});
                            word_cnt   <= word_cnt + 1'b1;
                            if ((word_cnt == W_LAST) || (timer == T_LAST)) begin
                                run_pending <= 1'b1;
                            end
                        end
                    end else if (timer == T_LAST) begin
                        state_q <= S_RUN;
                        cpu_run <= 1'b1;
                        if (byte_idx != 2'd0) begin
                            load_error <= 1'b1;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                S_RUN: begin
                    cpu_run <= 1'b1;
                end

                default: begin
                    state_q <= S_IDLE;
                    cpu_run <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_load_ctrl.sv
module tb_prog_load_ctrl;

    localparam int MW = 4;
    localparam int TO = 16;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_LOAD = 2'b01;
    localparam logic [1:0] ST_RUN  = 2'b10;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [31:0] cpu_addr;
    logic [31:0] pmem_addr;
    logic        pmem_we;
    logic [31:0] pmem_wdata;
    logic        cpu_run;
    logic [2:0]  load_words;
    logic        load_error;
    logic [1:0]  state;

    prog_load_ctrl #(.MEM_WORDS(MW), .TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .cpu_addr   (cpu_addr),
        .pmem_addr  (pmem_addr),
        .pmem_we    (pmem_we),
        .pmem_wdata (pmem_wdata),
        .cpu_run    (cpu_run),
        .load_words (load_words),
        .load_error (load_error),
        .state      (state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          words;
        int          stamp;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   last_stamp = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic send_byte(input logic [7:0] b);
        rx_valid   = 1'b1;
        rx_data    = b;
        last_stamp = cyc + 1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic exp_write(input logic [31:0] addr, input logic [31:0] data, input int words);
        exp_t e;
        e.addr  = addr;
        e.data  = data;
        e.words = words;
        e.stamp = last_stamp;
        q.push_back(e);
    endtask

    task automatic wait_run(input int exp_n, input string name);
        int n = 0;
        while (state != ST_RUN && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, n, exp_n);
    endtask

    task automatic do_reset(input string name);
        chk({name, "_pending_writes"}, q.size(), 0);
        q.delete();
        reset_n  = 1'b0;
        rx_valid = 1'b0;
        @(posedge clk); #1;
        mon_en = 1'b1;
        chk({name, "_state"},      state,      ST_IDLE);
        chk({name, "_cpu_run"},    cpu_run,    0);
        chk({name, "_we"},         pmem_we,    0);
        chk({name, "_wdata"},      pmem_wdata, 0);
        chk({name, "_words"},      load_words, 0);
        chk({name, "_error"},      load_error, 0);
        chk({name, "_addr"},       pmem_addr,  0);
        reset_n = 1'b1;
    endtask

    // Monitor: checks every write against the scoreboard and the port-level
    // invariants on every cycle.
    always @(negedge clk) begin
        if (mon_en && reset_n) begin
            if (pmem_we) begin
                chk("we_only_in_load", state, ST_LOAD);
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write addr=%h data=%h required=none", pmem_addr, pmem_wdata);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("wr_addr",  pmem_addr,  e.addr);
                    chk("wr_data",  pmem_wdata, e.data);
                    chk("wr_words", load_words, e.words);
                    chk("wr_cycle", cyc,        e.stamp);
                end
            end else if (state != ST_RUN) begin
                chk("addr_no_write", pmem_addr, 0);
            end
            if (state == ST_RUN) chk("run_addr", pmem_addr, cpu_addr);
            chk("cpu_run_vs_state", cpu_run, (state == ST_RUN) ? 1 : 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] full_words [4];

    initial begin
        reset_n  = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        cpu_addr = 32'h0;
        full_words[0] = 32'hA0A1A2A3;
        full_words[1] = 32'hB0B1B2B3;
        full_words[2] = 32'hC0C1C2C3;
        full_words[3] = 32'hD0D1D2D3;
        @(posedge clk); #1;

        // No bytes: RUN after 16 cycles, address passes through.
        do_reset("t1_reset");
        cpu_addr = 32'h0000_0100;
        wait_run(16, "t1_run_cycles");
        chk("t1_words", load_words, 0);
        cpu_addr = 32'h0000_0ABC;
        idle(2);
        cpu_addr = 32'hFFFF_FFFC;
        idle(2);

        // Two full words, then silence.
        do_reset("t2_reset");
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        exp_write(32'h0, 32'h13000000, 1);
        chk("t2_state_load", state, ST_LOAD);
        send_byte(8'hB3); send_byte(8'h05); send_byte(8'h00); send_byte(8'h00);
        exp_write(32'h4, 32'hB3050000, 2);
        wait_run(16, "t2_run_cycles");
        chk("t2_words", load_words, 2);
        chk("t2_error", load_error, 0);

        // Partial word at timeout.
        do_reset("t3_reset");
        send_byte(8'hAA); send_byte(8'hBB);
        wait_run(16, "t3_run_cycles");
        chk("t3_error", load_error, 1);
        chk("t3_words", load_words, 0);
        idle(3);
        chk("t3_error_sticky", load_error, 1);

        // Fill memory back-to-back; 17th and later bytes ignored.
        do_reset("t4_reset");
        cpu_addr = 32'h0000_0020;
        for (int w = 0; w < 4; w++) begin
            logic [31:0] wv;
            wv = full_words[w];
            send_byte(wv[31:24]); send_byte(wv[23:16]);
            send_byte(wv[15:8]);  send_byte(wv[7:0]);
            exp_write(32'(4 * w), wv, w + 1);
        end
        send_byte(8'hEE);
        wait_run(0, "t4_run_after_last_write");
        send_byte(8'hEF);
        idle(2);
        chk("t4_words", load_words, 4);
        chk("t4_error", load_error, 0);

        // Reset mid-load, then restart from word 0.
        do_reset("t5_reset");
        send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
        exp_write(32'h0, 32'h55667788, 1);
        send_byte(8'h99); send_byte(8'h9A);
        do_reset("t5_midload_reset");
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        exp_write(32'h0, 32'h01020304, 1);
        wait_run(16, "t5_run_cycles");
        chk("t5_words", load_words, 1);
        chk("t5_error", load_error, 0);

        // 4th byte lands on the timeout cycle: write, then RUN next cycle.
        do_reset("t6_reset");
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE);
        idle(15);
        send_byte(8'hEF);
        exp_write(32'h0, 32'hDEADBEEF, 1);
        wait_run(1, "t6_run_deferred");
        chk("t6_error", load_error, 0);
        chk("t6_words", load_words, 1);

        // 2nd byte on the timeout cycle: byte wins, load continues.
        do_reset("t7_reset");
        send_byte(8'h11);
        idle(15);
        send_byte(8'h22);
        chk("t7_state_load", state, ST_LOAD);
        send_byte(8'h33); send_byte(8'h44);
        exp_write(32'h0, 32'h11223344, 1);
        wait_run(16, "t7_run_cycles");
        chk("t7_error", load_error, 0);

        idle(2);
        chk("final_pending_writes", q.size(), 0);
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
